// File: rtl/axi_stream_split_pkg.sv
// Shared constants and types for the wide-to-72-bit AXI-Stream splitter.
package axi_stream_split_pkg;

  localparam int unsigned OSIZE = 72;

  typedef enum logic [1:0] {EMPTY, LO, HI} split_state_e;

  // Upper chunk of a beat that has been zero-extended to 2*OSIZE bits.
  function automatic logic [OSIZE-1:0] hi_chunk(input logic [2*OSIZE-1:0] data);
    return OSIZE'(data >> OSIZE);
  endfunction

endpackage

// File: rtl/axi_stream_split_143_to_72bit_if.sv
// Wide input stream and 72-bit output stream bundled for the splitter.
interface axi_stream_split_143_to_72bit_if #(
  parameter int unsigned DSIZE = 143
);

  logic [DSIZE-1:0]                      axis_in_tdata;
  logic                                  axis_in_tlast;
  logic                                  axis_in_tvalid;
  logic                                  axis_in_tready;
  logic [axi_stream_split_pkg::OSIZE-1:0] axis_out_tdata;
  logic                                  axis_out_tlast;
  logic                                  axis_out_tuser;
  logic                                  axis_out_tvalid;
  logic                                  axis_out_tready;

  // Splitter side: consumes the wide stream, produces the chunk stream.
  modport slave (
    input  axis_in_tdata, axis_in_tlast, axis_in_tvalid,
    output axis_in_tready,
    output axis_out_tdata, axis_out_tlast, axis_out_tuser, axis_out_tvalid,
    input  axis_out_tready
  );

  // Environment side: produces the wide stream, consumes the chunk stream.
  modport master (
    output axis_in_tdata, axis_in_tlast, axis_in_tvalid,
    input  axis_in_tready,
    input  axis_out_tdata, axis_out_tlast, axis_out_tuser, axis_out_tvalid,
    output axis_out_tready
  );

endinterface

// File: rtl/axi_stream_split_143_to_72bit.sv
// Splits each wide AXI-Stream beat into a LO and a zero-padded HI 72-bit chunk.
module axi_stream_split_143_to_72bit
  import axi_stream_split_pkg::*;
#(
  parameter int unsigned DSIZE = 143
) (
  input  logic aclk,
  input  logic areset,
  input  logic aclken,
  axi_stream_split_143_to_72bit_if.slave axis
);

  localparam int unsigned EXT_W = 2 * OSIZE;

  if (DSIZE < OSIZE + 1 || DSIZE > EXT_W - 1) begin : g_dsize_check
    $error("DSIZE must lie in 73..143");
  end

  split_state_e     state_q, state_d;
  logic [DSIZE-1:0] buf_data_q, buf_data_d;
  logic             buf_last_q, buf_last_d;
  logic             in_fire, out_fire;
  logic [EXT_W-1:0] buf_ext;

  assign buf_ext = EXT_W'(buf_data_q);

  // Accept in EMPTY, or in HI when the last chunk leaves this cycle.
  assign axis.axis_in_tready = !areset &&
                               (state_q == EMPTY || (state_q == HI && axis.axis_out_tready));

  assign in_fire  = axis.axis_in_tvalid && axis.axis_in_tready && aclken;
  assign out_fire = axis.axis_out_tvalid && axis.axis_out_tready && aclken;

  always_comb begin
    axis.axis_out_tvalid = (state_q != EMPTY);
    axis.axis_out_tuser  = (state_q == HI);
    axis.axis_out_tlast  = (state_q == HI) && buf_last_q;
    case (state_q)
      LO:      axis.axis_out_tdata = buf_data_q[OSIZE-1:0];
      HI:      axis.axis_out_tdata = hi_chunk(buf_ext);
      default: axis.axis_out_tdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = LO;
          buf_data_d = axis.axis_in_tdata;
          buf_last_d = axis.axis_in_tlast;
        end
      end
      LO: begin
        if (out_fire) state_d = HI;
      end
      HI: begin
        if (in_fire) begin
          state_d    = LO;
          buf_data_d = axis.axis_in_tdata;
          buf_last_d = axis.axis_in_tlast;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= EMPTY;
      buf_data_q <= '0;
      buf_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_split_143_to_72bit.sv
// Scoreboard bench for the splitter at DSIZE = 96, 128 and 143 side by side.
module tb_axi_stream_split_143_to_72bit;

  typedef struct packed {
    logic [71:0] data;
    logic        user;
    logic        last;
  } chunk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  function automatic void check(string name, logic [143:0] act, logic [143:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [159:0] rnd160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned DW = (k == 0) ? 96 : (k == 1) ? 128 : 143;

    logic        areset;
    logic        aclken;
    bit          fin = 1'b0;
    chunk_t      exp_q[$];
    int unsigned in_last_cnt  = 0;
    int unsigned out_last_cnt = 0;
    logic        hold_prev = 1'b0;
    chunk_t      prev;

    axi_stream_split_143_to_72bit_if #(.DSIZE(DW)) ifc ();

    axi_stream_split_143_to_72bit #(.DSIZE(DW)) dut (
      .aclk   (clk),
      .areset (areset),
      .aclken (aclken),
      .axis   (ifc.slave)
    );

    // Reference model: an accepted beat becomes its low 72 bits, then the rest shifted down.
    always @(negedge clk) begin
      if (aclken && ifc.axis_in_tvalid && ifc.axis_in_tready) begin
        exp_q.push_back({ifc.axis_in_tdata[71:0], 1'b0, 1'b0});
        exp_q.push_back({72'(ifc.axis_in_tdata >> 72), 1'b1, ifc.axis_in_tlast});
        if (ifc.axis_in_tlast) in_last_cnt++;
      end
    end

    always @(negedge clk) begin
      chunk_t c, e;
      c = {ifc.axis_out_tdata, ifc.axis_out_tuser, ifc.axis_out_tlast};
      if (areset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) check("stall_stable", c, prev);
        if (aclken && ifc.axis_out_tvalid && ifc.axis_out_tready) begin
          check("chunk_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("chunk", c, e);
          end
          if (c.user) check("pad_zero", 72'(c.data >> (DW - 72)), 0);
          if (c.last) out_last_cnt++;
        end
        hold_prev = ifc.axis_out_tvalid && !(aclken && ifc.axis_out_tready);
        prev = c;
      end
    end

    initial begin
      logic [DW-1:0] d, d2;
      logic          acc;
      int unsigned   sent;

      // Reset held for three edges with a valid beat waiting.
      areset = 1'b1;
      aclken = 1'b1;
      ifc.axis_out_tready = 1'b0;
      ifc.axis_in_tvalid  = 1'b1;
      ifc.axis_in_tdata   = DW'(rnd160());
      ifc.axis_in_tlast   = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        check("rst_out_tvalid", ifc.axis_out_tvalid, 0);
        check("rst_in_tready", ifc.axis_in_tready, 0);
      end
      areset = 1'b0;
      #1;
      check("rel_in_tready", ifc.axis_in_tready, 1);
      check("rel_out_tvalid", ifc.axis_out_tvalid, 0);
      check("rel_out_tdata", ifc.axis_out_tdata, 0);
      check("rel_out_tuser", ifc.axis_out_tuser, 0);
      check("rel_out_tlast", ifc.axis_out_tlast, 0);

      // Single beat with tlast.
      d = '1;
      d[79:0] = 80'hABCD_0123_4567_89AB_CDEF;
      ifc.axis_in_tdata   = d;
      ifc.axis_in_tlast   = 1'b1;
      ifc.axis_out_tready = 1'b1;
      @(posedge clk); #1;
      ifc.axis_in_tvalid = 1'b0;
      check("single_lo_valid", ifc.axis_out_tvalid, 1);
      check("single_lo_data", ifc.axis_out_tdata, 72'hCD_0123_4567_89AB_CDEF);
      check("single_lo_user", ifc.axis_out_tuser, 0);
      check("single_lo_last", ifc.axis_out_tlast, 0);
      @(posedge clk); #1;
      check("single_hi_data", ifc.axis_out_tdata, 72'(d >> 72));
      check("single_hi_user", ifc.axis_out_tuser, 1);
      check("single_hi_last", ifc.axis_out_tlast, 1);
      @(posedge clk); #1;
      check("single_idle", ifc.axis_out_tvalid, 0);

      // Eight back-to-back beats: one accept every other cycle, no output bubble.
      sent = 0;
      ifc.axis_in_tvalid = 1'b1;
      ifc.axis_in_tdata  = DW'(rnd160());
      ifc.axis_in_tlast  = 1'b0;
      for (int r = 0; r < 17; r++) begin
        @(negedge clk);
        check("stream_in_tready", ifc.axis_in_tready, (r % 2 == 0));
        if (r > 0) check("stream_out_tvalid", ifc.axis_out_tvalid, 1);
        acc = ifc.axis_in_tvalid && ifc.axis_in_tready;
        @(posedge clk); #1;
        if (acc) begin
          sent++;
          if (sent == 8) ifc.axis_in_tvalid = 1'b0;
          else begin
            ifc.axis_in_tdata = DW'(rnd160());
            ifc.axis_in_tlast = (sent == 7);
          end
        end
      end
      check("stream_sent", sent, 8);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: stall in LO for 5 cycles, then in HI for 3.
      ifc.axis_out_tready = 1'b0;
      ifc.axis_in_tvalid  = 1'b1;
      ifc.axis_in_tdata   = DW'(rnd160());
      ifc.axis_in_tlast   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      ifc.axis_in_tdata = DW'(rnd160());
      ifc.axis_in_tlast = 1'($urandom_range(0, 1));
      repeat (5) begin
        @(negedge clk);
        check("bp_lo_in_tready", ifc.axis_in_tready, 0);
        check("bp_lo_valid", ifc.axis_out_tvalid, 1);
        check("bp_lo_user", ifc.axis_out_tuser, 0);
        @(posedge clk); #1;
      end
      ifc.axis_out_tready = 1'b1;
      @(posedge clk); #1;
      ifc.axis_out_tready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("bp_hi_in_tready", ifc.axis_in_tready, 0);
        check("bp_hi_user", ifc.axis_out_tuser, 1);
        @(posedge clk); #1;
      end
      ifc.axis_out_tready = 1'b1;
      @(negedge clk);
      check("bp_release_in_tready", ifc.axis_in_tready, 1);
      @(posedge clk); #1;
      ifc.axis_in_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Clock enable low for 4 cycles while HI is presented.
      d = DW'(rnd160());
      d2 = DW'(rnd160());
      ifc.axis_in_tdata = d;
      ifc.axis_in_tlast = 1'b0;
      ifc.axis_in_tvalid = 1'b1;
      @(posedge clk); #1;
      ifc.axis_in_tdata = d2;
      @(posedge clk); #1;
      aclken = 1'b0;
      repeat (4) begin
        @(negedge clk);
        check("clken_valid", ifc.axis_out_tvalid, 1);
        check("clken_user", ifc.axis_out_tuser, 1);
        check("clken_data", ifc.axis_out_tdata, 72'(d >> 72));
        @(posedge clk); #1;
      end
      aclken = 1'b1;
      @(posedge clk); #1;
      ifc.axis_in_tvalid = 1'b0;
      @(negedge clk);
      check("clken_next_lo", ifc.axis_out_tdata, d2[71:0]);
      repeat (3) @(posedge clk);
      #1;

      // Reset while HI of a tlast beat is held: it must vanish.
      ifc.axis_in_tdata  = DW'(rnd160());
      ifc.axis_in_tlast  = 1'b1;
      ifc.axis_in_tvalid = 1'b1;
      @(posedge clk); #1;
      ifc.axis_in_tvalid = 1'b0;
      @(posedge clk); #1;
      ifc.axis_out_tready = 1'b0;
      check("pre_rst_hi_last", {ifc.axis_out_tuser, ifc.axis_out_tlast}, 2'b11);
      areset = 1'b1;
      foreach (exp_q[j]) if (exp_q[j].last) in_last_cnt--;
      exp_q.delete();
      repeat (2) begin
        @(posedge clk); #1;
        check("mid_rst_out_tvalid", ifc.axis_out_tvalid, 0);
        check("mid_rst_in_tready", ifc.axis_in_tready, 0);
      end
      areset = 1'b0;
      #1;
      check("mid_rel_in_tready", ifc.axis_in_tready, 1);
      check("mid_rel_out_tlast", ifc.axis_out_tlast, 0);
      ifc.axis_out_tready = 1'b1;
      repeat (2) begin
        @(posedge clk); #1;
        check("mid_rel_idle", ifc.axis_out_tvalid, 0);
      end
      d = DW'(rnd160());
      ifc.axis_in_tdata  = d;
      ifc.axis_in_tlast  = 1'b1;
      ifc.axis_in_tvalid = 1'b1;
      @(posedge clk); #1;
      ifc.axis_in_tvalid = 1'b0;
      check("post_rst_lo", {ifc.axis_out_tdata, ifc.axis_out_tuser}, {d[71:0], 1'b0});
      @(posedge clk); #1;
      check("post_rst_hi", {ifc.axis_out_tdata, ifc.axis_out_tuser, ifc.axis_out_tlast},
            {72'(d >> 72), 2'b11});
      @(posedge clk); #1;

      // Random traffic with random backpressure and clock-enable gaps.
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        acc = aclken && ifc.axis_in_tvalid && ifc.axis_in_tready;
        @(posedge clk); #1;
        if (acc || !ifc.axis_in_tvalid) begin
          ifc.axis_in_tvalid = ($urandom_range(0, 3) != 0);
          ifc.axis_in_tdata  = DW'(rnd160());
          ifc.axis_in_tlast  = ($urandom_range(0, 3) == 0);
        end
        ifc.axis_out_tready = ($urandom_range(0, 3) != 0);
        aclken = ($urandom_range(0, 7) != 0);
      end
      ifc.axis_in_tvalid  = 1'b0;
      ifc.axis_out_tready = 1'b1;
      aclken = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("drain_empty", exp_q.size(), 0);
      check("drain_idle", ifc.axis_out_tvalid, 0);
      check("tlast_count", out_last_cnt, in_last_cnt);
      fin = 1'b1;
    end
  end

  initial begin
    int unsigned cyc;
    cyc = 0;
    while (!(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check("all_done_in_time", {g_dut[0].fin, g_dut[1].fin, g_dut[2].fin}, 3'b111);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
